// File: rtl/onehot_dec_pkg.sv
// Shared types and sizes for the 3-to-8 one-hot decoder with handshakes.
package onehot_dec_pkg;

    localparam int IDX_W = 3;
    localparam int OUT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        HOLD  = 2'b10
    } state_e;

    function automatic logic [OUT_W-1:0] decode_idx(input logic [IDX_W-1:0] idx);
        logic [OUT_W-1:0] vec_v;
        vec_v      = {OUT_W{1'b0}};
        vec_v[idx] = 1'b1;
        return vec_v;
    endfunction

endpackage

// File: rtl/onehot_decoder_3x8_hs_dec_3x8.sv
// Purely combinational index-to-one-hot decoder; "none" forces an all-zero vector.
module dec_3x8
    import onehot_dec_pkg::*;
(
    input  logic [IDX_W-1:0] code,
    input  logic             none,
    output logic [OUT_W-1:0] vec
);

    // Select between the decoded line and the empty vector
    always_comb begin
        vec = {OUT_W{1'b0}};
        if (none) begin
            vec = {OUT_W{1'b0}};
        end else begin
            vec = decode_idx(code);
        end
    end

endmodule

// File: rtl/onehot_decoder_3x8_hs.sv
// Handshaked 3-to-8 one-hot regenerator: registers the decoded strobe, holds it a
// minimum time after the downstream accepts, and counts non-zero transfers.
module onehot_decoder_3x8_hs
    import onehot_dec_pkg::*;
#(
    parameter int MIN_HOLD = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_code,
    input  logic             in_none,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic [CNT_W-1:0] xfer_cnt,
    input  logic             cnt_clr
);

    localparam int              HOLD_W    = 4;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = (MIN_HOLD > 0) ? HOLD_W'(MIN_HOLD - 1) : {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_e              state_r;
    state_e              next_state_s;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [OUT_W-1:0]    dec_vec_s;
    logic                in_xfer_s;
    logic                out_xfer_s;

    dec_3x8 u_dec (
        .code (in_code),
        .none (in_none),
        .vec  (dec_vec_s)
    );

    assign in_ready   = (state_r == IDLE);
    assign in_xfer_s  = in_valid & in_ready;
    // out_ready is only meaningful while a vector is being offered
    assign out_xfer_s = out_valid & out_ready & (state_r == DRIVE);

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_xfer_s) begin
                    next_state_s = DRIVE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DRIVE: begin
                if (out_xfer_s) begin
                    next_state_s = (MIN_HOLD == 0) ? IDLE : HOLD;
                end else begin
                    next_state_s = DRIVE;
                end
            end
            HOLD: begin
                if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Output vector, valid flag and hold timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_onehot <= {OUT_W{1'b0}};
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_xfer_s) begin
                        out_onehot <= dec_vec_s;
                        out_valid  <= 1'b1;
                    end else begin
                        out_onehot <= {OUT_W{1'b0}};
                        out_valid  <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (out_xfer_s) begin
                        out_valid <= 1'b0;
                        if (MIN_HOLD == 0) begin
                            out_onehot <= {OUT_W{1'b0}};
                        end else begin
                            hold_cnt_r <= HOLD_LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                        out_onehot <= {OUT_W{1'b0}};
                    end else begin
                        hold_cnt_r <= hold_cnt_r - HOLD_ONE;
                    end
                end
                default: begin
                    out_valid  <= 1'b0;
                    out_onehot <= {OUT_W{1'b0}};
                    hold_cnt_r <= {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    // Saturating count of non-empty output transfers; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            xfer_cnt <= {CNT_W{1'b0}};
        end else if (out_xfer_s && (out_onehot != {OUT_W{1'b0}}) && (xfer_cnt != CNT_MAX)) begin
            xfer_cnt <= xfer_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_3x8_hs.sv
// Scoreboard bench for onehot_decoder_3x8_hs: three instances (MIN_HOLD 2/0/3) share stimulus.
module tb_onehot_decoder_3x8_hs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_none;
    logic [2:0] in_code;
    logic       out_ready;
    logic       cnt_clr;

    wire        ir0, ir1, ir2;
    wire        ov0, ov1, ov2;
    wire  [7:0] oh0, oh1, oh2;
    wire  [7:0] cnt0, cnt2;
    wire  [1:0] cnt1;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    onehot_decoder_3x8_hs #(.MIN_HOLD(2), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_code(in_code),
        .in_none(in_none), .out_valid(ov0), .out_ready(out_ready), .out_onehot(oh0),
        .xfer_cnt(cnt0), .cnt_clr(cnt_clr));

    onehot_decoder_3x8_hs #(.MIN_HOLD(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_code(in_code),
        .in_none(in_none), .out_valid(ov1), .out_ready(out_ready), .out_onehot(oh1),
        .xfer_cnt(cnt1), .cnt_clr(cnt_clr));

    onehot_decoder_3x8_hs #(.MIN_HOLD(3), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_code(in_code),
        .in_none(in_none), .out_valid(ov2), .out_ready(out_ready), .out_onehot(oh2),
        .xfer_cnt(cnt2), .cnt_clr(cnt_clr));

    function automatic logic get_ir(input int d);
        case (d)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        in_none   = 1'b0;
        in_code   = 3'd0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
    endtask

    // Called at a falling edge; returns once in_ready of instance d is seen high
    task automatic wait_in_ready(input int d, output bit ok);
        for (int k = 0; k < 50; k++) begin
            if (get_ir(d)) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        ok = 1'b0;
        checks++;
        errors++;
        $display("FAIL in_ready_timeout dut%0d got in_ready=0 want 1 within 50 cycles", d);
    endtask

    // Present one request to instance d, push its expected vector, return just after the accept edge
    task automatic accept(input int d, input logic [2:0] code, input logic none);
        bit         ok;
        logic [7:0] exp_v;
        in_valid = 1'b1;
        in_code  = code;
        in_none  = none;
        wait_in_ready(d, ok);
        if (ok) begin
            exp_v = 8'h01;
            exp_v = none ? 8'h00 : (exp_v << code);
            sb_q.push_back(exp_v);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_v;
        do_reset();
        #1;
        checks++; if (oh0 !== 8'h00) begin errors++; $display("FAIL reset_onehot got %h want 00", oh0); end
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov0); end
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir0); end
        @(negedge clk);
        accept(0, 3'd5, 1'b0);
        @(negedge clk);
        exp_v = sb_q.pop_front();
        checks++; if (oh0 !== exp_v) begin errors++; $display("FAIL drive_code5 got %h want %h", oh0, exp_v); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (oh0 !== 8'h00) begin errors++; $display("FAIL async_reset_onehot got %h want 00", oh0); end
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid got %b want 0", ov0); end
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready got %b want 1", ir0); end
        checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL async_reset_cnt got %0d want 0", cnt0); end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
    endtask

    task automatic test_sweep();
        out_ready = 1'b1;
        fork
            begin : producer
                bit         ok;
                int         last_t = 0;
                int         t;
                logic [7:0] exp_v;
                for (int i = 0; i < 8; i++) begin
                    in_valid = 1'b1;
                    in_code  = 3'(i);
                    in_none  = 1'b0;
                    wait_in_ready(0, ok);
                    if (!ok) break;
                    exp_v = 8'h01;
                    exp_v = exp_v << i;
                    sb_q.push_back(exp_v);
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                    t = cyc;
                    if (i > 0) begin
                        checks++;
                        if (t - last_t != 4) begin errors++; $display("FAIL sweep_accept_spacing got %0d want 4", t - last_t); end
                    end
                    last_t = t;
                    @(negedge clk);
                    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL sweep_latency code %0d got out_valid=%b want 1", i, ov0); end
                    @(negedge clk);
                end
            end
            begin : consumer
                bit         seen;
                logic [7:0] exp_v;
                for (int i = 0; i < 8; i++) begin
                    seen = 1'b0;
                    for (int k = 0; k < 50 && !seen; k++) begin
                        @(negedge clk);
                        seen = ov0;
                    end
                    checks++;
                    if (!seen || sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL sweep_output_timeout item %0d got none want out_valid", i);
                        break;
                    end
                    exp_v = sb_q.pop_front();
                    if (oh0 !== exp_v) begin errors++; $display("FAIL sweep_onehot item %0d got %h want %h", i, oh0, exp_v); end
                end
            end
        join
        begin
            bit ok;
            @(negedge clk);
            wait_in_ready(0, ok);
        end
        checks++; if (cnt0 !== 8'd8) begin errors++; $display("FAIL sweep_cnt got %0d want 8", cnt0); end
    endtask

    task automatic test_none();
        logic [7:0] exp_v;
        bit         ok;
        out_ready = 1'b1;
        accept(0, 3'd3, 1'b1);
        @(negedge clk);
        exp_v = sb_q.pop_front();
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL none_out_valid got %b want 1", ov0); end
        checks++; if (oh0 !== exp_v) begin errors++; $display("FAIL none_onehot got %h want %h", oh0, exp_v); end
        @(negedge clk);
        wait_in_ready(0, ok);
        checks++; if (cnt0 !== 8'd8) begin errors++; $display("FAIL none_cnt got %0d want 8", cnt0); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_v;
        bit         ok;
        out_ready = 1'b0;
        accept(0, 3'd6, 1'b0);
        exp_v    = sb_q.pop_front();
        in_valid = 1'b1;
        in_code  = 3'd2;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (ov0 !== 1'b1 || oh0 !== exp_v || ir0 !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cycle %0d got v=%b oh=%h rdy=%b want 1 %h 0", k, ov0, oh0, ir0, exp_v);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (ov0 !== 1'b0 || oh0 !== exp_v) begin errors++; $display("FAIL bp_release got v=%b oh=%h want 0 %h", ov0, oh0, exp_v); end
        wait_in_ready(0, ok);
        @(negedge clk);
        checks++; if (ov0 !== 1'b0 || oh0 !== 8'h00) begin errors++; $display("FAIL bp_second_accepted got v=%b oh=%h want 0 00", ov0, oh0); end
        checks++; if (cnt0 !== 8'd9) begin errors++; $display("FAIL bp_cnt got %0d want 9", cnt0); end
    endtask

    task automatic test_hold();
        logic [7:0] exp_v;
        do_reset();
        out_ready = 1'b1;
        accept(1, 3'd1, 1'b0);
        @(negedge clk);
        exp_v = sb_q.pop_front();
        checks++; if (ov1 !== 1'b1 || oh1 !== exp_v) begin errors++; $display("FAIL hold0_drive got v=%b oh=%h want 1 %h", ov1, oh1, exp_v); end
        @(negedge clk);
        checks++; if (oh1 !== 8'h00 || ir1 !== 1'b1) begin errors++; $display("FAIL hold0_release got oh=%h rdy=%b want 00 1", oh1, ir1); end

        do_reset();
        out_ready = 1'b1;
        accept(2, 3'd7, 1'b0);
        @(negedge clk);
        exp_v = sb_q.pop_front();
        checks++; if (ov2 !== 1'b1 || oh2 !== exp_v) begin errors++; $display("FAIL hold3_drive got v=%b oh=%h want 1 %h", ov2, oh2, exp_v); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (oh2 !== exp_v || ov2 !== 1'b0 || ir2 !== 1'b0) begin
                errors++;
                $display("FAIL hold3_cycle %0d got oh=%h v=%b rdy=%b want %h 0 0", k, oh2, ov2, ir2, exp_v);
            end
        end
        @(negedge clk);
        checks++; if (oh2 !== 8'h00 || ir2 !== 1'b1) begin errors++; $display("FAIL hold3_release got oh=%h rdy=%b want 00 1", oh2, ir2); end
    endtask

    task automatic test_counter();
        logic [7:0] exp_v;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            accept(1, 3'(i), 1'b0);
            @(negedge clk);
            exp_v = sb_q.pop_front();
            checks++; if (oh1 !== exp_v) begin errors++; $display("FAIL counter_onehot item %0d got %h want %h", i, oh1, exp_v); end
            @(negedge clk);
        end
        checks++; if (cnt1 !== 2'd3) begin errors++; $display("FAIL counter_saturate got %0d want 3", cnt1); end
        accept(1, 3'd4, 1'b0);
        @(negedge clk);
        void'(sb_q.pop_front());
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL counter_clr_wins got %0d want 0", cnt1); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_none();
        test_backpressure();
        test_hold();
        test_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "global timeout");
    end

endmodule
